// File: rtl/fp_norm_packer_if.sv
// Handshake bundle between an adder result producer, fp_norm_packer and the packed-word consumer.
interface fp_norm_packer_if #(
   parameter int MW = 16,
   parameter int EW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic          in_sign;
   logic [EW-1:0] in_exp;
   logic [MW:0]   in_mant;
   logic          out_valid;
   logic          out_ready;
   logic [EW+MW:0] out_word;
   logic          out_zero;
   logic          out_ovf;
   logic          out_unf;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, out_ready,
      input  in_ready, out_valid, out_word, out_zero, out_ovf, out_unf
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, out_ready,
      output in_ready, out_valid, out_word, out_zero, out_ovf, out_unf
   );
endinterface

// File: rtl/fp_norm_packer.sv
// Iterative normalizer/packer for a raw adder result: one shift per cycle, then {sign, exp, mant}.
// Define FP_ROUND_EN for round-to-nearest-even on right shifts; the default build truncates.
module fp_norm_packer #(
   parameter int MW = 16,
   parameter int EW = 8
) (
   input  logic            clk,
   input  logic            rst,
   fp_norm_packer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [EW-1:0] EXP_MAX = '1;

   state_t        state, state_n;
   logic          sign_r, sign_n;
   logic [EW-1:0] exp_r, exp_n;
   logic [MW:0]   mant_r, mant_n;
   logic          zero_r, zero_n;
   logic          ovf_r, ovf_n;
   logic          unf_r, unf_n;

   // A rounding carry back into bit MW is left for the next SHIFT step to absorb.
   function automatic logic [MW:0] rshift(input logic [MW:0] m);
      logic rnd;
`ifdef FP_ROUND_EN
      rnd = m[0] & m[1];
`else
      rnd = 1'b0;
`endif
      return {1'b0, m[MW:1]} + {{MW{1'b0}}, rnd};
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         sign_r <= 1'b0;
         exp_r  <= '0;
         mant_r <= '0;
         zero_r <= 1'b0;
         ovf_r  <= 1'b0;
         unf_r  <= 1'b0;
      end else begin
         state  <= state_n;
         sign_r <= sign_n;
         exp_r  <= exp_n;
         mant_r <= mant_n;
         zero_r <= zero_n;
         ovf_r  <= ovf_n;
         unf_r  <= unf_n;
      end
   end

   always_comb begin
      state_n = state;
      sign_n  = sign_r;
      exp_n   = exp_r;
      mant_n  = mant_r;
      zero_n  = zero_r;
      ovf_n   = ovf_r;
      unf_n   = unf_r;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               sign_n  = bus.in_sign;
               exp_n   = bus.in_exp;
               mant_n  = bus.in_mant;
               zero_n  = 1'b0;
               ovf_n   = 1'b0;
               unf_n   = 1'b0;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (mant_r == '0) begin
               exp_n   = '0;
               zero_n  = 1'b1;
               state_n = DONE;
            end else if (mant_r[MW]) begin
               if (exp_r == EXP_MAX) begin
                  mant_n  = '0;
                  ovf_n   = 1'b1;
                  state_n = DONE;
               end else begin
                  mant_n = rshift(mant_r);
                  exp_n  = exp_r + EW'(1);
               end
            end else if (mant_r[MW-1]) begin
               state_n = DONE;
            end else if (exp_r == '0) begin
               // Exponent exhausted: keep the denormal mantissa as it stands.
               unf_n   = 1'b1;
               state_n = DONE;
            end else begin
               mant_n = {mant_r[MW-1:0], 1'b0};
               exp_n  = exp_r - EW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_word  = {sign_r, exp_r, mant_r[MW-1:0]};
   assign bus.out_zero  = zero_r;
   assign bus.out_ovf   = ovf_r;
   assign bus.out_unf   = unf_r;
endmodule
